cw305_activity_monitor: RTL and testbench



---
 rtl/cw305_status_pkg.sv | 16 +
 rtl/cw305_activity_monitor_stretcher.sv | 58 +++++
 rtl/cw305_activity_monitor.sv | 109 ++++++++++
 tb/tb_cw305_activity_monitor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cw305_status_pkg.sv
// Shared definitions for the CW305 status/indicator block.
// Holds the trigger-measurement FSM state type and the parameter defaults.
package cw305_status_pkg;

    // Trigger-width measurement states
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } trig_state_e;

    localparam int unsigned NUM_CH_DEF      = 3;
    localparam int unsigned HB_WIDTH_DEF    = 23;
    localparam int unsigned STRETCH_LEN_DEF = 65535;
    localparam int unsigned TRIG_CNT_W_DEF  = 32;

endpackage

// File: rtl/cw305_activity_monitor_stretcher.sv
// activity_stretcher: one activity channel.
// Synchronises a raw asynchronous activity line, detects either edge and
// stretches each event into STRETCH_LEN cycles of LED-on time.
// Ports:
//   ext_clock  - block clock
//   AND_resets - async active-low reset
//   freeze     - hold the stretch counter and drop events
//   act_in     - raw asynchronous activity signal
//   act_led    - registered stretched indicator
module activity_stretcher
    import cw305_status_pkg::*;
#(
    parameter int unsigned STRETCH_LEN = STRETCH_LEN_DEF
) (
    input  logic ext_clock,
    input  logic AND_resets,
    input  logic freeze,
    input  logic act_in,
    output logic act_led
);

    localparam int unsigned STRETCH_W = $clog2(STRETCH_LEN + 1);

    logic                 sync1;
    logic                 sync2;
    logic                 sync3;
    logic [STRETCH_W-1:0] cnt;
    logic                 event_c;

    // Either polarity of the synchronised input counts as activity
    assign event_c = sync2 ^ sync3;

    // Synchroniser, edge-detect flop and stretch counter
    always_ff @(posedge ext_clock or negedge AND_resets) begin
        if (!AND_resets) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            cnt     <= '0;
            act_led <= 1'b0;
        end else begin
            sync1   <= act_in;
            sync2   <= sync1;
            sync3   <= sync2;
            // Frozen cycles neither count nor accept events; a reload
            // on the last lit cycle keeps the LED on without a gap.
            if (!freeze) begin
                if (event_c) begin
                    cnt <= STRETCH_W'(STRETCH_LEN);
                end else if (cnt != '0) begin
                    cnt <= cnt - STRETCH_W'(1);
                end
            end
            act_led <= (cnt != '0);
        end
    end

endmodule

// File: rtl/cw305_activity_monitor.sv
// cw305_activity_monitor: LED / measurement status block for the CW305 top.
// Heartbeat divider, NUM_CH stretched activity indicators and a trigger
// pulse-width counter. Heartbeat and stretchers freeze while the capture
// trigger is high and quiet_en is set; trigger measurement never freezes.
// Ports:
//   ext_clock     - block clock
//   AND_resets    - async active-low reset
//   trig_in       - capture trigger (synchronous)
//   quiet_en      - enable freezing during trigger
//   act_in        - raw asynchronous activity lines
//   hb_out        - heartbeat, MSB of free-running counter
//   act_led       - stretched activity indicators
//   trig_cycles   - width of last completed trigger pulse (saturating)
//   trig_valid    - one-cycle strobe when trig_cycles updates
//   trig_overflow - last measurement saturated
module cw305_activity_monitor
    import cw305_status_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned HB_WIDTH    = HB_WIDTH_DEF,
    parameter int unsigned STRETCH_LEN = STRETCH_LEN_DEF,
    parameter int unsigned TRIG_CNT_W  = TRIG_CNT_W_DEF
) (
    input  logic                  ext_clock,
    input  logic                  AND_resets,
    input  logic                  trig_in,
    input  logic                  quiet_en,
    input  logic [NUM_CH-1:0]     act_in,
    output logic                  hb_out,
    output logic [NUM_CH-1:0]     act_led,
    output logic [TRIG_CNT_W-1:0] trig_cycles,
    output logic                  trig_valid,
    output logic                  trig_overflow
);

    logic                  freeze_c;
    logic [HB_WIDTH-1:0]   hb_cnt;
    trig_state_e           state;
    logic                  trig_d;
    logic [TRIG_CNT_W-1:0] meas_cnt;
    logic                  meas_ovf;

    assign freeze_c = quiet_en & trig_in;
    assign hb_out   = hb_cnt[HB_WIDTH-1];

    // Heartbeat divider, wraps naturally
    always_ff @(posedge ext_clock or negedge AND_resets) begin
        if (!AND_resets) begin
            hb_cnt <= '0;
        end else if (!freeze_c) begin
            hb_cnt <= hb_cnt + HB_WIDTH'(1);
        end
    end

    // One stretcher per activity channel
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        activity_stretcher #(
            .STRETCH_LEN (STRETCH_LEN)
        ) u_stretch (
            .ext_clock  (ext_clock),
            .AND_resets (AND_resets),
            .freeze     (freeze_c),
            .act_in     (act_in[i]),
            .act_led    (act_led[i])
        );
    end

    // Trigger-width measurement FSM with registered outputs
    always_ff @(posedge ext_clock or negedge AND_resets) begin
        if (!AND_resets) begin
            state         <= IDLE;
            trig_d        <= 1'b0;
            meas_cnt      <= '0;
            meas_ovf      <= 1'b0;
            trig_cycles   <= '0;
            trig_valid    <= 1'b0;
            trig_overflow <= 1'b0;
        end else begin
            trig_d     <= trig_in;
            trig_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_in && !trig_d) begin
                        meas_cnt <= TRIG_CNT_W'(1);
                        meas_ovf <= 1'b0;
                        state    <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (trig_in) begin
                        // Saturate rather than wrap on very long pulses
                        if (&meas_cnt) begin
                            meas_ovf <= 1'b1;
                        end else begin
                            meas_cnt <= meas_cnt + TRIG_CNT_W'(1);
                        end
                    end else begin
                        trig_cycles   <= meas_cnt;
                        trig_overflow <= meas_ovf;
                        trig_valid    <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cw305_activity_monitor.sv
// Scoreboard bench for cw305_activity_monitor with small parameters.
// A reference model turns each sampled clock edge into expected outputs;
// a monitor on the falling edge compares them with the DUT.
module tb_cw305_activity_monitor;

    localparam int NCH  = 3;
    localparam int HBW  = 4;
    localparam int SL   = 4;
    localparam int TW   = 4;
    localparam int TMAX = (1 << TW) - 1;
    localparam int MAXE = 8192;

    logic           ext_clock  = 1'b0;
    logic           AND_resets = 1'b0;
    logic           trig_in    = 1'b0;
    logic           quiet_en   = 1'b0;
    logic [NCH-1:0] act_in     = '0;
    logic           hb_out;
    logic [NCH-1:0] act_led;
    logic [TW-1:0]  trig_cycles;
    logic           trig_valid;
    logic           trig_overflow;

    int checks = 0;
    int errors = 0;

    cw305_activity_monitor #(
        .NUM_CH      (NCH),
        .HB_WIDTH    (HBW),
        .STRETCH_LEN (SL),
        .TRIG_CNT_W  (TW)
    ) dut (
        .ext_clock     (ext_clock),
        .AND_resets    (AND_resets),
        .trig_in       (trig_in),
        .quiet_en      (quiet_en),
        .act_in        (act_in),
        .hb_out        (hb_out),
        .act_led       (act_led),
        .trig_cycles   (trig_cycles),
        .trig_valid    (trig_valid),
        .trig_overflow (trig_overflow)
    );

    always #5 ext_clock = ~ext_clock;

    typedef struct {
        logic           hb;
        logic [NCH-1:0] led;
        logic           vld;
    } cyc_exp_t;

    typedef struct {
        int   cyc;
        logic ovf;
    } trig_exp_t;

    cyc_exp_t  cyc_q[$];
    trig_exp_t trig_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edges since reset, unfrozen-edge prefix counts,
    // last accepted event per channel and current trigger run length.
    logic [NCH-1:0] act_hist [0:MAXE];
    int             ufz      [0:MAXE];
    int             last_load[NCH];
    int             ec;
    int             run;

    always @(posedge ext_clock or negedge AND_resets) begin
        cyc_exp_t  e;
        trig_exp_t t;
        logic      frz;
        logic      s2;
        logic      s3;
        if (!AND_resets) begin
            ec          = 0;
            act_hist[0] = '0;
            ufz[0]      = 0;
            run         = 0;
            for (int c = 0; c < NCH; c++) last_load[c] = -1;
            cyc_q.delete();
            trig_q.delete();
        end else begin
            ec++;
            if (ec >= MAXE) begin
                $display("FAIL model_overrun: got %0d expected below %0d", ec, MAXE);
                $fatal(1, "model history exhausted");
            end
            frz          = quiet_en & trig_in;
            act_hist[ec] = act_in;
            ufz[ec]      = ufz[ec-1] + (frz ? 0 : 1);
            for (int c = 0; c < NCH; c++) begin
                // LED reflects whether any stretch time remains as of the previous edge
                e.led[c] = (last_load[c] >= 1) &&
                           ((SL - (ufz[ec-1] - ufz[last_load[c]])) > 0);
                s2 = (ec >= 2) ? act_hist[ec-2][c] : 1'b0;
                s3 = (ec >= 3) ? act_hist[ec-3][c] : 1'b0;
                if ((s2 != s3) && !frz) last_load[c] = ec;
            end
            e.hb  = ((ufz[ec] >> (HBW - 1)) & 1) != 0;
            e.vld = 1'b0;
            if (trig_in) begin
                run++;
            end else if (run > 0) begin
                e.vld = 1'b1;
                t.cyc = (run > TMAX) ? TMAX : run;
                t.ovf = (run > TMAX);
                trig_q.push_back(t);
                run = 0;
            end
            cyc_q.push_back(e);
        end
    end

    // Monitor: compare per-cycle expectations and trigger results
    logic [TW-1:0] held_cyc = '0;
    logic          held_ovf = 1'b0;

    always @(negedge ext_clock) begin
        cyc_exp_t  e;
        trig_exp_t t;
        if (!AND_resets) begin
            held_cyc = '0;
            held_ovf = 1'b0;
        end else begin
            while (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("hb_out", int'(hb_out), int'(e.hb));
                chk("act_led", int'(act_led), int'(e.led));
                chk("trig_valid", int'(trig_valid), int'(e.vld));
            end
            if (trig_valid) begin
                if (trig_q.size() == 0) begin
                    chk("trig_unexpected", 1, 0);
                end else begin
                    t        = trig_q.pop_front();
                    held_cyc = TW'(t.cyc);
                    held_ovf = t.ovf;
                end
            end
            chk("trig_cycles", int'(trig_cycles), int'(held_cyc));
            chk("trig_overflow", int'(trig_overflow), int'(held_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ext_clock);
            #2;
        end
    endtask

    task automatic pulse(input int width, input int gap);
        trig_in = 1'b1;
        tick(width);
        trig_in = 1'b0;
        tick(gap);
    endtask

    initial begin
        tick(3);
        chk("rst_hb", int'(hb_out), 0);
        chk("rst_led", int'(act_led), 0);
        chk("rst_cycles", int'(trig_cycles), 0);
        chk("rst_valid", int'(trig_valid), 0);
        chk("rst_ovf", int'(trig_overflow), 0);
        AND_resets = 1'b1;
        tick(40);

        // Single toggle on channel 1
        act_in[1] = ~act_in[1];
        tick(10);

        // Retrigger on channel 0 three cycles later
        act_in[0] = ~act_in[0];
        tick(3);
        act_in[0] = ~act_in[0];
        tick(12);

        // Trigger widths: normal, saturating, boundary, 1-cycle, back-to-back
        pulse(5, 4);
        pulse(20, 4);
        pulse(15, 3);
        pulse(16, 3);
        pulse(1, 3);
        pulse(6, 1);
        pulse(4, 4);

        // Quiet window with activity inside, then the same without quiet
        for (int q = 1; q >= 0; q--) begin
            quiet_en = q[0];
            trig_in  = 1'b1;
            tick(3);
            act_in[2] = ~act_in[2];
            tick(7);
            trig_in = 1'b0;
            tick(10);
        end
        quiet_en = 1'b0;

        // Reset in the middle of a measurement
        trig_in = 1'b1;
        tick(5);
        AND_resets = 1'b0;
        tick(2);
        trig_in = 1'b0;
        tick(2);
        chk("midrst_cycles", int'(trig_cycles), 0);
        chk("midrst_valid", int'(trig_valid), 0);
        AND_resets = 1'b1;
        tick(3);
        pulse(3, 4);

        // Randomised traffic on all inputs
        repeat (600) begin
            if ($urandom_range(0, 9) == 0) trig_in = ~trig_in;
            if ($urandom_range(0, 29) == 0) quiet_en = ~quiet_en;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 11) == 0) act_in[c] = ~act_in[c];
            tick(1);
        end
        trig_in  = 1'b0;
        quiet_en = 1'b0;
        tick(12);

        chk("trig_q_drained", trig_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
